// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: FSM encoding and default sizes shared by the multiplier arbiter files
package mult_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mult_arb_sched_if.sv
// mult_arb_sched_if: requester-side bus of the shared multiplier (requests, operands, completion)
interface mult_arb_sched_if import mult_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int W = W_DEF
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic busy;
  logic [NREQ-1:0] done;
  logic [2*W-1:0] result;
  logic [IW-1:0] result_id;
  modport master (output req, a_in, b_in, input busy, done, result, result_id);
  modport slave (input req, a_in, b_in, output busy, done, result, result_id);
endinterface

// File: rtl/mult_arb_sched_shift_add_core.sv
// shift_add_core: W-step shift-add unsigned multiplier; A sits in the low half of the accumulator
module shift_add_core import mult_arb_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_step,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [2*W-1:0] o_prod,
  output logic o_last
);
  localparam int CW = $clog2(W) + 1;
  logic [2*W:0] r_acc;
  logic [W-1:0] r_b;
  logic [CW-1:0] r_cnt;
  logic [W:0] w_sum;
  // bit 2W is always zero after a shift, so it doubles as the carry guard for the add
  assign w_sum = r_acc[2*W:W] + (r_acc[0] ? {1'b0, r_b} : '0);
  assign o_prod = r_acc[2*W-1:0];
  assign o_last = r_cnt == CW'(W - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_b <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= {{(W + 1){1'b0}}, i_a};
      r_b <= i_b;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= {1'b0, w_sum, r_acc[W-1:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mult_arb_sched.sv
// mult_arb_sched: round-robin arbiter sharing one shift-add multiplier among NREQ requesters
module mult_arb_sched import mult_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int W = W_DEF
) (
  input logic clk,
  input logic reset,
  mult_arb_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_t r_state, w_next;
  logic [IW-1:0] r_last, r_result_id, w_win;
  logic [2*W-1:0] r_result, w_prod;
  logic [W-1:0] w_a, w_b;
  logic w_any, w_load, w_step, w_last;
  // scan from farthest to nearest so the requester right after r_last wins
  always_comb begin
    w_win = r_last;
    for (int k = NREQ; k >= 1; k--)
      if (bus.req[(int'(r_last) + k) % NREQ]) w_win = IW'((int'(r_last) + k) % NREQ);
  end
  assign w_any = |bus.req;
  assign w_a = bus.a_in[int'(w_win) * W +: W];
  assign w_b = bus.b_in[int'(w_win) * W +: W];
  shift_add_core #(.W(W)) u_core (
    .clk(clk),
    .reset(reset),
    .i_load(w_load),
    .i_step(w_step),
    .i_a(w_a),
    .i_b(w_b),
    .o_prod(w_prod),
    .o_last(w_last)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (w_any ? CALC : IDLE) :
             r_state == CALC ? (w_last ? DONE : CALC) : IDLE;
  end
  always_comb begin
    w_load = r_state == IDLE && w_any;
    w_step = r_state == CALC;
    bus.busy = r_state != IDLE;
    bus.done = r_state == DONE ? {{(NREQ - 1){1'b0}}, 1'b1} << r_last : '0;
    bus.result = r_state == DONE ? w_prod : r_result;
    bus.result_id = r_state == DONE ? r_last : r_result_id;
  end
  // r_last doubles as the owner of the operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= IW'(NREQ - 1);
      r_result <= '0;
      r_result_id <= '0;
    end else begin
      if (w_load) r_last <= w_win;
      if (r_state == DONE) begin
        r_result <= w_prod;
        r_result_id <= r_last;
      end
    end
  end
endmodule

// File: tb/tb_mult_arb_sched.sv
// tb_mult_arb_sched: directed and randomized checks of the shared multiplier against a round-robin model
module tb_mult_arb_sched;
  localparam int NREQ = 4;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_win;
  int t0, t1;
  int oa[NREQ];
  int ob[NREQ];
  logic [NREQ-1:0] pending;
  mult_arb_sched_if #(.NREQ(NREQ), .W(W)) bus ();
  mult_arb_sched #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic set_op(input int id, input int a, input int b);
    bus.a_in[id*W +: W] = W'(a);
    bus.b_in[id*W +: W] = W'(b);
    bus.req[id] = 1'b1;
  endtask
  // round-robin model: first requester after the previous winner
  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction
  task automatic run_op(input int id, input int exp, input bit drop, input bit early, output int t_done);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy !== 1'b1 && n < 20);
    chk("grant", 32'(bus.busy), 1);
    n = 1;
    while (bus.done === '0 && n < 20) begin
      if (early && n == 1) bus.req[id] = 1'b0;
      @(negedge clk);
      n++;
    end
    t_done = cyc;
    chk("latency", n, W + 1);
    chk("done", 32'(bus.done), 1 << id);
    chk("result", 32'(bus.result), exp);
    chk("result_id", 32'(bus.result_id), id);
    chk("busy_in_done", 32'(bus.busy), 1);
    if (drop) bus.req[id] = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_done", 32'(bus.done), 0);
    chk("hold_result", 32'(bus.result), exp);
    chk("hold_id", 32'(bus.result_id), id);
  endtask
  initial begin
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_id", 32'(bus.result_id), 0);
    reset = 1'b0;
    set_op(0, 13, 11);
    run_op(0, 143, 1, 0, t0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_op(0, 3, 5);
    set_op(1, 15, 15);
    set_op(2, 0, 9);
    set_op(3, 7, 1);
    run_op(0, 15, 1, 0, t0);
    run_op(1, 225, 1, 0, t1);
    chk("spacing01", t1 - t0, W + 2);
    run_op(2, 0, 1, 0, t0);
    chk("spacing12", t0 - t1, W + 2);
    run_op(3, 7, 1, 0, t1);
    chk("spacing23", t1 - t0, W + 2);
    for (int i = 0; i < NREQ; i++) begin
      oa[i] = $urandom_range(0, 15);
      ob[i] = $urandom_range(0, 15);
    end
    set_op(1, oa[1], ob[1]);
    set_op(3, oa[3], ob[3]);
    run_op(1, oa[1] * ob[1], 0, 0, t0);
    run_op(3, oa[3] * ob[3], 0, 0, t0);
    run_op(1, oa[1] * ob[1], 0, 0, t0);
    bus.req[1] = 1'b0;
    run_op(3, oa[3] * ob[3], 1, 0, t0);
    set_op(0, 9, 7);
    @(negedge clk);
    chk("mid_busy1", 32'(bus.busy), 1);
    @(negedge clk);
    chk("mid_busy2", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_result", 32'(bus.result), 0);
    @(negedge clk);
    chk("mid_rst_done2", 32'(bus.done), 0);
    reset = 1'b0;
    run_op(0, 63, 1, 0, t0);
    set_op(0, 5, 6);
    run_op(0, 30, 1, 1, t0);
    repeat (3) begin
      @(negedge clk);
      chk("withdraw_idle", 32'(bus.busy), 0);
    end
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        set_op(2, a, b);
        run_op(2, a * b, 1, 0, t0);
      end
    last_win = 2;
    repeat (40) begin
      pending = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        if (pending[i]) begin
          oa[i] = $urandom_range(0, 15);
          ob[i] = $urandom_range(0, 15);
          set_op(i, oa[i], ob[i]);
        end
      while (pending != '0) begin
        automatic int id = rr_next(pending, last_win);
        run_op(id, oa[id] * ob[id], 1, 0, t0);
        pending[id] = 1'b0;
        last_win = id;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_arb_sched.md
MULT_ARB_SCHED -- requirements
Module: mult_arb_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, the number of requesters sharing one multiplier (2..8).
REQ-002 The block SHALL have parameter W, default 4, the operand width in bits.
REQ-003 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req  input  NREQ  per-requester request level.
REQ-006 The block SHALL have port a_in  input  NREQ*W  multiplicand A of requester i in bits [i*W +: W].
REQ-007 The block SHALL have port b_in  input  NREQ*W  multiplier B of requester i in bits [i*W +: W].
REQ-008 The block SHALL have port busy  output  1  high while an operation is in CALC or DONE.
REQ-009 The block SHALL have port done  output  NREQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-010 The block SHALL have port result  output  2*W  unsigned product A*B, valid while any done bit is high.
REQ-011 The block SHALL have port result_id  output  clog2(NREQ)  index of the requester owning result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 In IDLE with any req high, the next edge SHALL select a winner round-robin, latch its A and B, clear the accumulator and a bit counter, and enter CALC.
REQ-014 The round-robin search SHALL start at (last_winner+1) mod NREQ; last_winner SHALL update only on a grant.
REQ-015 CALC SHALL last exactly W cycles, one shift-add step per cycle: if acc[0]=1, acc[2W:W] <= {0,acc[2W-1:W]}+B, then acc shifted right by one, all in the same cycle.
REQ-016 The accumulator SHALL be 2W+1 bits wide so no carry is lost; result SHALL equal acc[2W-1:0] after W steps.
REQ-017 After the W-th CALC cycle, the block SHALL enter DONE for exactly one cycle, with done[result_id]=1, result and result_id valid, then return to IDLE.
REQ-018 Latency from the grant edge to done high SHALL be W+1 cycles; back-to-back throughput SHALL be one product per W+2 cycles.
REQ-019 A requester SHALL hold req, a_in and b_in stable until it sees its done bit; operands SHALL be sampled only at the grant edge.
REQ-020 req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-021 req dropping during CALC SHALL NOT abort the operation; done SHALL still pulse.
REQ-022 req changes in CALC or DONE SHALL be ignored until the next IDLE.
REQ-023 result and result_id SHALL hold their last values outside DONE; done SHALL be zero outside DONE.
REQ-024 Zero operands SHALL give result 0; A=B=2^W-1 SHALL give (2^W-1)^2 with no overflow.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, busy=0, done=0, result=0, result_id=0, acc=0, counter=0, last_winner=NREQ-1, so requester 0 wins first.
REQ-026 Reset during CALC or DONE SHALL abort the operation with no done pulse; after reset deasserts, the first edge with req high SHALL grant normally.

Structure
REQ-027 The state encoding (IDLE/CALC/DONE) and the default W/NREQ constants SHALL reside in the shared package mult_arb_pkg.
REQ-028 The shift-add datapath (accumulator, bit counter, load/step controls) SHALL be the sub-module shift_add_core; arbitration and the FSM SHALL stay in mult_arb_sched.

Verification
REQ-029 Single request: req=0001, A0=13, B0=11 -> done=0001 exactly 5 cycles after the grant edge, result=143, result_id=0.
REQ-030 Contention: req=1111 held, with operands (3,5),(15,15),(0,9),(7,1) -> completions in order id 0,1,2,3 with results 15,225,0,7, spaced 6 cycles apart.
REQ-031 Fairness: req=1010 held continuously -> grants alternate 1,3,1,3 with no starvation.
REQ-032 Reset mid-operation: assert reset in the 2nd CALC cycle -> busy=0 and done=0 immediately, no done pulse; the next request completes correctly.
REQ-033 Request withdrawal: req0 drops in the 1st CALC cycle -> done[0] still pulses once, then IDLE with busy=0.
REQ-034 Exhaustive: all 256 A,B pairs on requester 2 -> result=A*B every time, result_id=2.
